// File: rtl/tx232c_fifo.sv
// tx232c_fifo: buffered 8N1 RS-232C transmitter.
// Core-side bytes go into a small circular FIFO. A four-state serializer
// (IDLE/START/DATA/STOP) drains the FIFO LSB-first onto RS_TX, which idles high.
// Frames leave back-to-back while the FIFO has data, with no idle bit between them.
//
// Handshake: push is a fire-and-forget valid. It is accepted on a rising CLK
// edge only when the registered full flag is low. A push seen while full is
// dropped and latches the sticky overflow flag, even if a pop happens on that
// same edge.
module tx232c_fifo #(
  parameter int CLKS_PER_BIT = 620,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  CLK,
  input  logic                  XRST,
  input  logic [7:0]            data,
  input  logic                  push,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  busy,
  output logic                  overflow,
  output logic                  RS_TX
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;

  state_t        state;
  state_t        state_n;
  logic [BW-1:0] baud;
  logic [BW-1:0] baud_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic          tx_n;
  logic          pop;
  logic          wr_en;
  logic          baud_tc;
  logic          has_data;

  // count never exceeds DEPTH, so its MSB is set exactly when the FIFO is full.
  assign full     = count[DEPTH_LOG2];
  assign wr_en    = push & ~full;
  assign baud_tc  = (baud == BAUD_LAST);
  assign has_data = (count != '0);
  assign busy     = (state != S_IDLE) | has_data;

  // FIFO storage: the write port has no reset; the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wptr] <= data;
  end

  // FIFO pointers, occupancy count and the sticky overflow flag.
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full) overflow <= 1'b1;
    end
  end

  // Serializer state register. RS_TX is registered, so the line never glitches.
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      RS_TX   <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      RS_TX   <= tx_n;
    end
  end

  // Serializer next-state logic. tx_n is the line level for the next state.
  always_comb begin
    state_n = state;
    baud_n  = baud + 1'b1;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = RS_TX;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (has_data) begin
          pop     = 1'b1;
          shift_n = mem[rptr];
          state_n = S_START;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        tx_n = 1'b0;
        if (baud_tc) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = S_DATA;
          tx_n    = shift[0];
        end
      end
      S_DATA: begin
        tx_n = shift[0];
        if (baud_tc) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            shift_n = {1'b0, shift[7:1]};
            bit_n   = bit_idx + 3'd1;
            tx_n    = shift[1];
          end
        end
      end
      S_STOP: begin
        tx_n = 1'b1;
        if (baud_tc) begin
          baud_n = '0;
          if (has_data) begin
            // Chain straight into the next start bit; no idle gap.
            pop     = 1'b1;
            shift_n = mem[rptr];
            state_n = S_START;
            tx_n    = 1'b0;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        baud_n  = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_tx232c_fifo.sv
// Directed testbench for tx232c_fifo with CLKS_PER_BIT=4 and DEPTH_LOG2=2.
// Inputs change and outputs are sampled on the falling CLK edge. Index 0 of
// line_buf is the first clock of the first start bit in each scenario.
module tb_tx232c_fifo;

  localparam int CPB   = 4;
  localparam int DL    = 2;
  localparam int FRAME = 10 * CPB;

  // Clock and reset
  logic          CLK  = 1'b0;
  logic          XRST = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          push = 1'b0;
  logic          full;
  logic [DL:0]   count;
  logic          busy;
  logic          overflow;
  logic          RS_TX;

  int total = 0;
  int bad   = 0;
  logic line_buf [0:299];

  always #5 CLK = ~CLK;

  tx232c_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL)) dut (
    .CLK(CLK), .XRST(XRST), .data(data), .push(push), .full(full),
    .count(count), .busy(busy), .overflow(overflow), .RS_TX(RS_TX)
  );

  // Expected line level for bit k (0=start, 1..8=data LSB first, 9=stop).
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Driver tasks
  task automatic do_reset();
    @(negedge CLK);
    push = 1'b0;
    XRST = 1'b0;
    repeat (2) @(negedge CLK);
    XRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic record(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      line_buf[start + i] = RS_TX;
    end
  endtask

  task automatic test_reset();
    XRST = 1'b0;
    data = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      push = i[0];
      @(negedge CLK);
      total++; if (RS_TX !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", RS_TX); end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    end
    push = 1'b0;
    XRST = 1'b1;
    repeat (3) @(negedge CLK);
    total++; if (RS_TX !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset: tx=%b busy=%b want 1/0", RS_TX, busy); end
  endtask

  task automatic test_single();
    logic [7:0] exp_line;
    exp_line = 8'hA5;
    data = 8'hA5;
    push = 1'b1;
    @(negedge CLK);
    push = 1'b0;
    total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count1: got %0d want 1", count); end
    total++; if (RS_TX !== 1'b1) begin bad++; $display("FAIL single_tx_pre: got %b want 1", RS_TX); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    @(negedge CLK);
    total++; if (count !== 3'd0) begin bad++; $display("FAIL single_count0: got %0d want 0", count); end
    for (int k = 0; k < 10; k++) begin
      total++;
      if (RS_TX !== exp_bit(exp_line, k)) begin
        bad++; $display("FAIL single_bit%0d: got %b want %b", k, RS_TX, exp_bit(exp_line, k));
      end
      repeat (CPB) @(negedge CLK);
    end
    total++; if (busy !== 1'b0 || RS_TX !== 1'b1) begin bad++; $display("FAIL single_done: busy=%b tx=%b want 0/1", busy, RS_TX); end
  endtask

  task automatic test_burst();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int peak;
    int lows;
    logic saw_full;
    logic [DL:0] last_count;
    peak = 0;
    saw_full = 1'b0;
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    data = 8'h01;
    push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (int'(count) > peak) peak = int'(count);
      if (full) saw_full = 1'b1;
      if (i >= 1) line_buf[i-1] = RS_TX;
      if (i < 3) data = 8'(i + 2);
      else push = 1'b0;
    end
    last_count = count;
    total++; if (last_count !== 3'd3) begin bad++; $display("FAIL burst_count: got %0d want 3", last_count); end
    total++; if (peak != 3) begin bad++; $display("FAIL burst_peak: got %0d want 3", peak); end
    total++; if (saw_full !== 1'b0) begin bad++; $display("FAIL burst_full: got %b want 0", saw_full); end
    record(3, 4 * FRAME + 10 - 3);
    for (int f = 0; f < 4; f++) begin
      b = exp_q.pop_front();
      for (int k = 0; k < 10; k++) begin
        lows = 0;
        for (int s = 0; s < CPB; s++)
          if (line_buf[f*FRAME + k*CPB + s] !== exp_bit(b, k)) lows++;
        total++;
        if (lows != 0) begin bad++; $display("FAIL burst_f%0d_bit%0d: %0d clocks wrong, want %b", f, k, lows, exp_bit(b, k)); end
      end
    end
    lows = 0;
    for (int i = 4 * FRAME; i < 4 * FRAME + 10; i++) if (line_buf[i] !== 1'b1) lows++;
    total++; if (lows != 0) begin bad++; $display("FAIL burst_idle: got %0d low clocks want 0", lows); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL burst_busy: got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int lows;
    do_reset();
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    data = 8'h10;
    push = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (i >= 1) line_buf[i-1] = RS_TX;
      if (i == 4) begin
        total++; if (full !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL ovf_full: full=%b count=%0d want 1/4", full, count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
      if (i == 5) begin
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", count); end
      end
      if (i < 5) data = 8'(8'h11 + i);
      else push = 1'b0;
    end
    record(5, 5 * FRAME + 20 - 5);
    for (int f = 0; f < 5; f++) begin
      b = exp_q.pop_front();
      for (int k = 0; k < 10; k++) begin
        lows = 0;
        for (int s = 0; s < CPB; s++)
          if (line_buf[f*FRAME + k*CPB + s] !== exp_bit(b, k)) lows++;
        total++;
        if (lows != 0) begin bad++; $display("FAIL ovf_f%0d_bit%0d: %0d clocks wrong, want %b", f, k, lows, exp_bit(b, k)); end
      end
    end
    lows = 0;
    for (int i = 5 * FRAME; i < 5 * FRAME + 20; i++) if (line_buf[i] !== 1'b1) lows++;
    total++; if (lows != 0) begin bad++; $display("FAIL ovf_sixth_frame: got %0d low clocks want 0", lows); end
    total++; if (busy !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL ovf_done: busy=%b count=%0d want 0/0", busy, count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_reset_midframe();
    int lows;
    logic was_busy;
    do_reset();
    data = 8'hFF;
    push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (i == 0) data = 8'hAA;
      else if (i == 1) data = 8'hBB;
      else push = 1'b0;
    end
    total++; if (count !== 3'd2) begin bad++; $display("FAIL mid_count_pre: got %0d want 2", count); end
    // Now at frame clock 1; move to frame clock 17 (inside data bit 3).
    repeat (16) @(negedge CLK);
    XRST = 1'b0;
    #1;
    total++; if (RS_TX !== 1'b1) begin bad++; $display("FAIL mid_tx: got %b want 1", RS_TX); end
    total++; if (count !== 3'd0 || full !== 1'b0) begin bad++; $display("FAIL mid_count: count=%0d full=%b want 0/0", count, full); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    @(negedge CLK);
    XRST = 1'b1;
    lows = 0;
    was_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (RS_TX !== 1'b1) lows++;
      if (busy !== 1'b0) was_busy = 1'b1;
    end
    total++; if (lows != 0) begin bad++; $display("FAIL mid_no_frames: got %0d low clocks want 0", lows); end
    total++; if (was_busy !== 1'b0) begin bad++; $display("FAIL mid_busy_after: got %b want 0", was_busy); end
  endtask

  task automatic test_push_pop();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int lows;
    do_reset();
    exp_q = '{8'h21, 8'h22, 8'h23, 8'h24};
    data = 8'h20;
    push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (i < 4) data = 8'(8'h21 + i);
      else push = 1'b0;
    end
    total++; if (count !== 3'd4 || full !== 1'b1) begin bad++; $display("FAIL pp_fill: count=%0d full=%b want 4/1", count, full); end
    // Frame clock 3 -> frame clock 39, the last stop-bit clock.
    repeat (36) @(negedge CLK);
    total++; if (count !== 3'd4 || overflow !== 1'b0 || RS_TX !== 1'b1) begin bad++; $display("FAIL pp_pre: count=%0d ovf=%b tx=%b want 4/0/1", count, overflow, RS_TX); end
    data = 8'h99;
    push = 1'b1;
    @(negedge CLK);
    push = 1'b0;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL pp_count: got %0d want 3", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL pp_ovf: got %b want 1", overflow); end
    total++; if (RS_TX !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL pp_start: tx=%b full=%b want 0/0", RS_TX, full); end
    line_buf[0] = RS_TX;
    record(1, 4 * FRAME + 10 - 1);
    for (int f = 0; f < 4; f++) begin
      b = exp_q.pop_front();
      for (int k = 0; k < 10; k++) begin
        lows = 0;
        for (int s = 0; s < CPB; s++)
          if (line_buf[f*FRAME + k*CPB + s] !== exp_bit(b, k)) lows++;
        total++;
        if (lows != 0) begin bad++; $display("FAIL pp_f%0d_bit%0d: %0d clocks wrong, want %b", f, k, lows, exp_bit(b, k)); end
      end
    end
    lows = 0;
    for (int i = 4 * FRAME; i < 4 * FRAME + 10; i++) if (line_buf[i] !== 1'b1) lows++;
    total++; if (lows != 0) begin bad++; $display("FAIL pp_dropped_sent: got %0d low clocks want 0", lows); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_reset_midframe();
    test_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
